stop_watch_ctrl: RTL and testbench
==================================

STOP_WATCH_CTRL -- requirements
Module: stop_watch_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 2_000_000, number of consecutive stable samples needed before a button level is accepted (legal range >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port arst_n  input  1  reset, synchronous and active-low, sampled on rising clk.
REQ-004 SHALL have port btn_start  input  1  raw, asynchronous start/stop button, high = pressed.
REQ-005 SHALL have port btn_lap  input  1  raw, asynchronous lap button, high = pressed.
REQ-006 SHALL have port btn_clr  input  1  raw, asynchronous clear button, high = pressed.
REQ-007 SHALL have ports sec_0 [3:0], sec_1 [2:0], min_0 [3:0], min_1 [2:0], hr_0 [3:0], hr_1 [0:0], all inputs carrying the live BCD time from the stopwatch counter.
REQ-008 SHALL have port cnt_en  output  1  count enable to the stopwatch counter.
REQ-009 SHALL have port clr  output  1  one-cycle clear pulse to the stopwatch counter.
REQ-010 SHALL have ports d_sec_0, d_sec_1, d_min_0, d_min_1, d_hr_0, d_hr_1, all outputs with the same widths as the time inputs, carrying the display time.
REQ-011 SHALL have ports running  output  1  (state RUN or LAP) and lap_active  output  1  (state LAP).

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer.
REQ-013 SHALL debounce each button as follows:
- Per-button counter increments while the synchronized level differs from the debounced level, and clears when they match.
- When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the new value and the counter clears.
REQ-014 SHALL generate a one-cycle event on each debounced 0->1 transition. Releases generate no event.
REQ-015 SHALL change state on the clock edge after the event. Total latency is DEBOUNCE_CYCLES+3 edges, counting from the first edge that samples the button high.
REQ-016 SHALL implement the FSM with states IDLE, RUN, PAUSE and LAP. Transitions:
- IDLE: start -> RUN; clr -> IDLE, with the clr pulse issued.
- RUN: start -> PAUSE; lap -> LAP, capturing the time inputs into the lap registers on the same edge; clr is ignored.
- PAUSE: start -> RUN; clr -> IDLE, with the clr pulse issued.
- LAP: lap -> RUN; start -> PAUSE (display returns to live); clr is ignored.
REQ-017 SHALL resolve simultaneous events with priority clr > start > lap. Only the highest-priority event that is legal in the current state is acted on; all others are discarded.
REQ-018 SHALL register cnt_en so that it is 1 exactly while the state is RUN or LAP.
REQ-019 SHALL register clr high for exactly one cycle, on the same edge the FSM enters IDLE from a clr event, and low at all other times.
REQ-020 SHALL drive the display outputs from the lap registers in LAP, and pass the live time inputs through combinationally in every other state.
REQ-021 SHALL produce exactly one event for a button held continuously, regardless of hold duration.
REQ-022 SHALL produce no event for a glitch shorter than DEBOUNCE_CYCLES stable samples.

Reset
REQ-023 SHALL, while arst_n=0 at a clock edge, reset the following: state=IDLE, cnt_en=0, clr=0, running=0, lap_active=0, synchronizers=0, debounced levels=0, debounce counters=0, lap registers=0.
REQ-024 SHALL abort any in-progress debounce or event on reset, with no event emitted.
REQ-025 SHALL treat a button held through reset release as a new press, producing one event DEBOUNCE_CYCLES+3 edges after release.

Configuration
REQ-026 SHALL gate the lap feature with macro STOP_WATCH_CTRL_LAP_EN, with the following behaviour:
- Defined: full lap behaviour per REQ-016 and REQ-020.
- Undefined: btn_lap is ignored, the LAP state and lap registers are absent, lap_active is tied 0, and the display outputs always equal the live inputs.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 SHALL cover: after reset, hold btn_start high for 10 cycles -> cnt_en goes 1 on the 7th edge after first sampling, running=1, exactly one transition.
REQ-028 SHALL cover: in RUN, a 2-cycle btn_start glitch -> no state change, cnt_en stays 1.
REQ-029 SHALL cover (macro defined): in RUN with live time 00:12:37, press lap -> lap_active=1 and display frozen at 00:12:37 while the inputs advance; a second lap press -> display follows live input.
REQ-030 SHALL cover: in PAUSE, btn_clr and btn_start pressed together -> clr pulses for exactly 1 cycle, state IDLE, cnt_en=0.
REQ-031 SHALL cover: in RUN, press btn_clr -> no clr pulse, cnt_en remains 1.
REQ-032 SHALL cover: arst_n low for 1 cycle in LAP while btn_start is held -> all outputs 0, then RUN entered 7 edges after reset release.

Source files
------------

// File: rtl/stop_watch_ctrl.sv
// Stopwatch control: button synchronize/debounce, start/stop/lap/clear FSM and display mux.
// Optional lap feature enabled by defining STOP_WATCH_CTRL_LAP_EN.
module stop_watch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clr,
    input  logic [3:0] sec_0,
    input  logic [2:0] sec_1,
    input  logic [3:0] min_0,
    input  logic [2:0] min_1,
    input  logic [3:0] hr_0,
    input  logic [0:0] hr_1,
    output logic       cnt_en,
    output logic       clr,
    output logic [3:0] d_sec_0,
    output logic [2:0] d_sec_1,
    output logic [3:0] d_min_0,
    output logic [2:0] d_min_1,
    output logic [3:0] d_hr_0,
    output logic [0:0] d_hr_1,
    output logic       running,
    output logic       lap_active
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam int BI_START = 0;
    localparam int BI_CLR   = 1;
`ifdef STOP_WATCH_CTRL_LAP_EN
    localparam int BI_LAP   = 2;
    localparam int NB       = 3;
`else
    localparam int NB       = 2;
`endif

    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_event;

    assign btn_raw[BI_START] = btn_start;
    assign btn_raw[BI_CLR]   = btn_clr;
`ifdef STOP_WATCH_CTRL_LAP_EN
    assign btn_raw[BI_LAP]   = btn_lap;
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
`endif

    // Each button: 2-flop synchronizer, then a counter that must see the new level
    // DEBOUNCE_CYCLES times in a row before the debounced level follows.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          level_reg;
            logic          event_reg;
            logic [CW-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (!arst_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    event_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    event_reg <= 1'b0;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        level_reg <= sync2_reg;
                        event_reg <= sync2_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            end

            assign btn_event[gi] = event_reg;
        end
    endgenerate

    logic ev_start;
    logic ev_clr;
    assign ev_start = btn_event[BI_START];
    assign ev_clr   = btn_event[BI_CLR];

`ifdef STOP_WATCH_CTRL_LAP_EN
    logic ev_lap;
    assign ev_lap = btn_event[BI_LAP];
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_LAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;
`endif

    state_t state_reg;
    state_t state_next;
    logic   clr_next;
    logic   cnt_en_reg;
    logic   clr_reg;
    logic   cnt_en_next;
`ifdef STOP_WATCH_CTRL_LAP_EN
    logic   lap_load;
`endif

    // Priority clr > start > lap among the events legal in the current state.
    always_comb begin
        state_next = state_reg;
        clr_next   = 1'b0;
`ifdef STOP_WATCH_CTRL_LAP_EN
        lap_load   = 1'b0;
`endif
        case (state_reg)
            S_IDLE: begin
                if (ev_clr) begin
                    clr_next = 1'b1;
                end else if (ev_start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (ev_start) begin
                    state_next = S_PAUSE;
`ifdef STOP_WATCH_CTRL_LAP_EN
                end else if (ev_lap) begin
                    state_next = S_LAP;
                    lap_load   = 1'b1;
`endif
                end
            end
            S_PAUSE: begin
                if (ev_clr) begin
                    state_next = S_IDLE;
                    clr_next   = 1'b1;
                end else if (ev_start) begin
                    state_next = S_RUN;
                end
            end
`ifdef STOP_WATCH_CTRL_LAP_EN
            S_LAP: begin
                if (ev_start) begin
                    state_next = S_PAUSE;
                end else if (ev_lap) begin
                    state_next = S_RUN;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

`ifdef STOP_WATCH_CTRL_LAP_EN
    assign cnt_en_next = (state_next == S_RUN) || (state_next == S_LAP);
`else
    assign cnt_en_next = (state_next == S_RUN);
`endif

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_reg  <= S_IDLE;
            cnt_en_reg <= 1'b0;
            clr_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_en_reg <= cnt_en_next;
            clr_reg    <= clr_next;
        end
    end

    assign cnt_en = cnt_en_reg;
    assign clr    = clr_reg;

    logic [18:0] live_time;
    logic [18:0] disp_time;
    assign live_time = {hr_1, hr_0, min_1, min_0, sec_1, sec_0};

`ifdef STOP_WATCH_CTRL_LAP_EN
    logic [18:0] lap_time_reg;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            lap_time_reg <= '0;
        end else if (lap_load) begin
            lap_time_reg <= live_time;
        end
    end

    assign disp_time  = (state_reg == S_LAP) ? lap_time_reg : live_time;
    assign running    = (state_reg == S_RUN) || (state_reg == S_LAP);
    assign lap_active = (state_reg == S_LAP);
`else
    assign disp_time  = live_time;
    assign running    = (state_reg == S_RUN);
    assign lap_active = 1'b0;
`endif

    assign {d_hr_1, d_hr_0, d_min_1, d_min_0, d_sec_1, d_sec_0} = disp_time;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Directed bench for stop_watch_ctrl (DEBOUNCE_CYCLES=4) with a window-based behavioural model.
// Lap scenarios are selected with STOP_WATCH_CTRL_LAP_EN, matching the RTL build.
module tb_stop_watch_ctrl;

    localparam int D = 4;
`ifdef STOP_WATCH_CTRL_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;
    localparam int E_START = 0, E_CLR = 1, E_LAP = 2;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       btn_start = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
    logic [3:0] sec_0 = '0, min_0 = '0, hr_0 = '0;
    logic [2:0] sec_1 = '0, min_1 = '0;
    logic [0:0] hr_1 = '0;
    logic       cnt_en, clr, running, lap_active;
    logic [3:0] d_sec_0, d_min_0, d_hr_0;
    logic [2:0] d_sec_1, d_min_1;
    logic [0:0] d_hr_1;

    int cmp_count = 0;
    int err_count = 0;
    bit check_en  = 1'b0;

    always #5 clk = ~clk;

    stop_watch_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .arst_n(arst_n),
        .btn_start(btn_start), .btn_lap(btn_lap), .btn_clr(btn_clr),
        .sec_0(sec_0), .sec_1(sec_1), .min_0(min_0), .min_1(min_1), .hr_0(hr_0), .hr_1(hr_1),
        .cnt_en(cnt_en), .clr(clr),
        .d_sec_0(d_sec_0), .d_sec_1(d_sec_1), .d_min_0(d_min_0), .d_min_1(d_min_1),
        .d_hr_0(d_hr_0), .d_hr_1(d_hr_1),
        .running(running), .lap_active(lap_active)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_state = M_IDLE;
    bit   [2:0]  m_ev    = '0;
    bit   [2:0]  m_deb   = '0;
    logic [31:0] m_samp [3];
    bit          m_clr   = 1'b0;
    logic [18:0] m_lap   = '0;

    function automatic bit legal(input int s, input int e);
        case (s)
            M_IDLE:  return (e == E_START) || (e == E_CLR);
            M_RUN:   return (e == E_START) || ((e == E_LAP) && LAP_EN);
            M_PAUSE: return (e == E_START) || (e == E_CLR);
            default: return (e == E_START) || (e == E_LAP);
        endcase
    endfunction

    function automatic int dest(input int s, input int e);
        if (e == E_CLR)   return M_IDLE;
        if (e == E_START) return ((s == M_RUN) || (s == M_LAP)) ? M_PAUSE : M_RUN;
        return (s == M_RUN) ? M_LAP : M_RUN;
    endfunction

    function automatic logic [18:0] live_time();
        return {hr_1, hr_0, min_1, min_0, sec_1, sec_0};
    endfunction

    always @(posedge clk) begin : model
        logic [2:0] raw;
        bit   [2:0] new_ev;
        int         prio [3];
        int         act;
        raw = {btn_lap, btn_clr, btn_start};
        if (!arst_n) begin
            m_state = M_IDLE;
            m_ev    = '0;
            m_deb   = '0;
            m_clr   = 1'b0;
            m_lap   = '0;
            for (int b = 0; b < 3; b++) m_samp[b] = '0;
        end else begin
            prio = '{E_CLR, E_START, E_LAP};
            act  = -1;
            for (int p = 0; p < 3; p++)
                if (act < 0 && m_ev[prio[p]] && legal(m_state, prio[p])) act = prio[p];
            m_clr = (act == E_CLR);
            if (act >= 0) begin
                if (m_state == M_RUN && act == E_LAP) m_lap = live_time();
                m_state = dest(m_state, act);
            end
            // Debounced level flips once the last D synchronized samples all disagree with it.
            new_ev = '0;
            for (int b = 0; b < 3; b++) begin
                m_samp[b] = {m_samp[b][30:0], raw[b]};
                if (m_samp[b][D+1:2] == {D{~m_deb[b]}}) begin
                    m_deb[b]  = ~m_deb[b];
                    new_ev[b] = m_deb[b];
                end
            end
            m_ev = new_ev;
        end
    end

    always @(posedge clk) begin : compare
        #2;
        if (check_en) begin
            check("cyc_cnt_en", 32'(cnt_en), 32'(m_state == M_RUN || m_state == M_LAP));
            check("cyc_running", 32'(running), 32'(m_state == M_RUN || m_state == M_LAP));
            check("cyc_lap_active", 32'(lap_active), 32'(m_state == M_LAP));
            check("cyc_clr", 32'(clr), 32'(m_clr));
            check("cyc_display", 32'({d_hr_1, d_hr_0, d_min_1, d_min_0, d_sec_1, d_sec_0}),
                  32'((m_state == M_LAP) ? m_lap : live_time()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_time(input int h, input int m, input int s);
        @(negedge clk);
        hr_1 = 1'(h / 10); hr_0 = 4'(h % 10);
        min_1 = 3'(m / 10); min_0 = 4'(m % 10);
        sec_1 = 3'(s / 10); sec_0 = 4'(s % 10);
    endtask

    task automatic press(input string tag, input bit s, input bit c, input bit l,
                         input int hold, input int settle, output int clr_pulses);
        @(negedge clk);
        btn_start = s; btn_clr = c; btn_lap = l;
        clr_pulses = 0;
        repeat (hold) begin
            @(posedge clk); #2;
            if (clr === 1'b1) clr_pulses++;
        end
        @(negedge clk);
        btn_start = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0;
        repeat (settle) begin
            @(posedge clk); #2;
            if (clr === 1'b1) clr_pulses++;
        end
        $display("press %s: start=%0b clr=%0b lap=%0b hold=%0d -> running=%0b lap_active=%0b clr_pulses=%0d",
                 tag, s, c, l, hold, running, lap_active, clr_pulses);
    endtask

    // Caller has just raised btn_start at a negedge; edge 1 is the next rising edge.
    task automatic watch_start(input string tag);
        int   toggles;
        logic prev;
        prev = running;
        toggles = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #2;
            if (running !== prev) toggles++;
            prev = running;
            if (i == 6) check({tag, "_cnt_en_edge6"}, 32'(cnt_en), 32'd0);
            if (i == 7) check({tag, "_cnt_en_edge7"}, 32'(cnt_en), 32'd1);
        end
        check({tag, "_transitions"}, 32'(toggles), 32'd1);
        check({tag, "_running"}, 32'(running), 32'd1);
        $display("start hold %s: running=%0b cnt_en=%0b transitions=%0d", tag, running, cnt_en, toggles);
    endtask

    initial begin : stim
        int n;
        repeat (3) @(negedge clk);
        check("rst_cnt_en", 32'(cnt_en), 32'd0);
        check("rst_clr", 32'(clr), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_lap_active", 32'(lap_active), 32'd0);
        $display("reset: cnt_en=%0b clr=%0b running=%0b lap_active=%0b", cnt_en, clr, running, lap_active);
        check_en = 1'b1;
        arst_n   = 1'b1;

        // Start held 10 cycles: RUN on edge 7, one transition.
        @(negedge clk);
        btn_start = 1'b1;
        watch_start("first_start");
        @(negedge clk);
        btn_start = 1'b0;
        repeat (10) @(negedge clk);

        // Short glitch must be rejected.
        press("glitch", 1'b1, 1'b0, 1'b0, 2, 10, n);
        check("glitch_cnt_en", 32'(cnt_en), 32'd1);
        check("glitch_running", 32'(running), 32'd1);

        // Clear is ignored while running.
        press("clr_in_run", 1'b0, 1'b1, 1'b0, 8, 10, n);
        check("run_clr_pulses", 32'(n), 32'd0);
        check("run_clr_cnt_en", 32'(cnt_en), 32'd1);

        set_time(0, 12, 37);
`ifdef STOP_WATCH_CTRL_LAP_EN
        press("lap_on", 1'b0, 1'b0, 1'b1, 8, 6, n);
        check("lap_active_on", 32'(lap_active), 32'd1);
        check("lap_d_min", 32'({d_min_1, d_min_0}), 32'h12);
        check("lap_d_sec", 32'({d_sec_1, d_sec_0}), 32'h37);
        set_time(0, 12, 45);
        @(posedge clk); #2;
        check("lap_frozen_sec", 32'({d_sec_1, d_sec_0}), 32'h37);
        check("lap_cnt_en", 32'(cnt_en), 32'd1);
        press("lap_off", 1'b0, 1'b0, 1'b1, 8, 6, n);
        check("lap_active_off", 32'(lap_active), 32'd0);
        check("lap_live_sec", 32'({d_sec_1, d_sec_0}), 32'h45);
`else
        press("lap_ignored", 1'b0, 1'b0, 1'b1, 8, 6, n);
        check("nolap_active", 32'(lap_active), 32'd0);
        check("nolap_running", 32'(running), 32'd1);
        check("nolap_live_sec", 32'({d_sec_1, d_sec_0}), 32'h37);
`endif

        // RUN -> PAUSE, then clr+start together in PAUSE: clear wins.
        press("pause", 1'b1, 1'b0, 1'b0, 8, 10, n);
        check("pause_cnt_en", 32'(cnt_en), 32'd0);
        check("pause_running", 32'(running), 32'd0);
        press("clr_and_start", 1'b1, 1'b1, 1'b0, 8, 10, n);
        check("pause_clr_pulses", 32'(n), 32'd1);
        check("pause_clr_cnt_en", 32'(cnt_en), 32'd0);
        check("pause_clr_running", 32'(running), 32'd0);

        press("clr_in_idle", 1'b0, 1'b1, 1'b0, 8, 10, n);
        check("idle_clr_pulses", 32'(n), 32'd1);
        check("idle_clr_running", 32'(running), 32'd0);

        press("restart", 1'b1, 1'b0, 1'b0, 8, 10, n);
        check("restart_running", 32'(running), 32'd1);
`ifdef STOP_WATCH_CTRL_LAP_EN
        press("lap_before_reset", 1'b0, 1'b0, 1'b1, 8, 6, n);
        check("pre_reset_lap_active", 32'(lap_active), 32'd1);
`endif

        // Reset pulse with start held: in-flight debounce aborted, new press after release.
        @(negedge clk);
        btn_start = 1'b1;
        @(negedge clk);
        arst_n = 1'b0;
        @(posedge clk); #2;
        check("rst2_cnt_en", 32'(cnt_en), 32'd0);
        check("rst2_clr", 32'(clr), 32'd0);
        check("rst2_running", 32'(running), 32'd0);
        check("rst2_lap_active", 32'(lap_active), 32'd0);
        $display("mid-run reset: cnt_en=%0b running=%0b lap_active=%0b", cnt_en, running, lap_active);
        @(negedge clk);
        arst_n = 1'b1;
        watch_start("after_reset");
        @(negedge clk);
        btn_start = 1'b0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
